// File: rtl/dfd_dst_vlt_decoder.sv
// Receive-side decoder for DST VLT packets: rebuilds XOR-compressed, byte-sparse samples and timestamps.
// Optional statistics counters are enabled by defining DFD_DST_VLT_DECODER_STATS_EN.
module dfd_dst_vlt_decoder #(
  parameter int unsigned DEBUG_SIGNAL_WIDTH = 64,
  parameter int unsigned BE_WIDTH           = DEBUG_SIGNAL_WIDTH / 8,
  parameter int unsigned SRC_ID_WIDTH       = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cfg_xor_en,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DEBUG_SIGNAL_WIDTH-1:0] out_data,
  output logic [SRC_ID_WIDTH-1:0]       out_source_id,
  output logic                          out_packet_lost,
  output logic [1:0]                    out_trace_info,
  output logic                          ts_valid,
  output logic [63:0]                   ts_value,
  output logic                          err_pulse
`ifdef DFD_DST_VLT_DECODER_STATS_EN
  ,
  output logic [31:0]                   stat_data_pkts,
  output logic [31:0]                   stat_lost_pkts,
  output logic [15:0]                   stat_err_cnt
`endif
);

  typedef enum logic [2:0] {HDR0, HDR1, PAYLOAD, OUT, SUP1, TS} state_e;

  state_e                          state_q, state_d;
  logic [SRC_ID_WIDTH-1:0]         src_q, out_src_q;
  logic                            lost_q, out_lost_q;
  logic [1:0]                      tinfo_q, out_tinfo_q;
  logic                            xor_q;
  logic [BE_WIDTH-1:0]             be_rem_q;
  logic [DEBUG_SIGNAL_WIDTH-1:0]   delta_q, ref_q, out_data_q;
  logic                            out_valid_q;
  logic [63:0]                     ts_shift_q, ts_value_q;
  logic [2:0]                      ts_cnt_q;
  logic                            ts_valid_q, err_q;

  logic                            xfer, err_d;
  logic [BE_WIDTH-1:0]             lowest, rem_nx;
  logic [DEBUG_SIGNAL_WIDTH-1:0]   delta_nx, base;

  assign xfer = in_valid && in_ready;

  // be_rem_q holds the lanes still to be filled; each byte lands in the lowest one left.
  always_comb begin
    lowest   = be_rem_q & (~be_rem_q + BE_WIDTH'(1));
    rem_nx   = be_rem_q & ~lowest;
    delta_nx = delta_q;
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      if (lowest[i]) delta_nx[8*i +: 8] = in_byte;
    end
    base = ((tinfo_q != 2'b00) || !xor_q) ? '0 : ref_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= HDR0;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    err_d    = 1'b0;
    in_ready = (state_q != OUT);
    case (state_q)
      HDR0: if (xfer) begin
        if (!in_byte[7])     state_d = HDR1;
        else if (in_byte[0]) state_d = HDR0;
        else if (in_byte[1]) state_d = SUP1;
        else                 err_d   = 1'b1;
      end
      HDR1: if (xfer) begin
        if (BE_WIDTH'(in_byte) == '0) begin
          err_d   = 1'b1;
          state_d = HDR0;
        end else begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (xfer && (rem_nx == '0)) state_d = OUT;
      OUT:     if (out_ready) state_d = HDR0;
      SUP1: if (xfer) begin
        if (in_byte[7:4] == 4'h1) state_d = TS;
        else begin
          err_d   = 1'b1;
          state_d = HDR0;
        end
      end
      TS:      if (xfer && (ts_cnt_q == 3'd7)) state_d = HDR0;
      default: state_d = HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q       <= '0;
      lost_q      <= 1'b0;
      tinfo_q     <= '0;
      xor_q       <= 1'b0;
      be_rem_q    <= '0;
      delta_q     <= '0;
      ref_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_lost_q  <= 1'b0;
      out_tinfo_q <= '0;
      ts_shift_q  <= '0;
      ts_value_q  <= '0;
      ts_cnt_q    <= '0;
      ts_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q      <= err_d;
      ts_valid_q <= 1'b0;
      if (state_q == HDR0 && xfer && !in_byte[7]) begin
        src_q   <= SRC_ID_WIDTH'(in_byte[6:3]);
        lost_q  <= in_byte[2];
        tinfo_q <= in_byte[1:0];
      end
      if (state_q == HDR1 && xfer) begin
        be_rem_q <= BE_WIDTH'(in_byte);
        delta_q  <= '0;
        xor_q    <= cfg_xor_en;
      end
      if (state_q == PAYLOAD && xfer) begin
        delta_q  <= delta_nx;
        be_rem_q <= rem_nx;
        if (rem_nx == '0) begin
          out_valid_q <= 1'b1;
          out_data_q  <= base ^ delta_nx;
          out_src_q   <= src_q;
          out_lost_q  <= lost_q;
          out_tinfo_q <= tinfo_q;
        end
      end
      if (state_q == OUT && out_ready) begin
        out_valid_q <= 1'b0;
        ref_q       <= out_data_q;
      end
      if (state_q == SUP1 && xfer) ts_cnt_q <= '0;
      if (state_q == TS && xfer) begin
        ts_shift_q <= {in_byte, ts_shift_q[63:8]};
        ts_cnt_q   <= ts_cnt_q + 3'd1;
        if (ts_cnt_q == 3'd7) begin
          ts_valid_q <= 1'b1;
          ts_value_q <= {in_byte, ts_shift_q[63:8]};
        end
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign out_source_id   = out_src_q;
  assign out_packet_lost = out_lost_q;
  assign out_trace_info  = out_tinfo_q;
  assign ts_valid        = ts_valid_q;
  assign ts_value        = ts_value_q;
  assign err_pulse       = err_q;

`ifdef DFD_DST_VLT_DECODER_STATS_EN
  logic [31:0] data_cnt_q, lost_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_cnt_q <= '0;
      lost_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (state_q == OUT && out_ready) begin
        if (data_cnt_q != '1)               data_cnt_q <= data_cnt_q + 32'd1;
        if (out_lost_q && lost_cnt_q != '1) lost_cnt_q <= lost_cnt_q + 32'd1;
      end
      if (err_q && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign stat_data_pkts = data_cnt_q;
  assign stat_lost_pkts = lost_cnt_q;
  assign stat_err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_dfd_dst_vlt_decoder.sv
// Directed bench for dfd_dst_vlt_decoder: packet table plus backpressure and mid-packet reset sequences.
module tb_dfd_dst_vlt_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_xor_en;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_source_id;
  logic        out_packet_lost;
  logic [1:0]  out_trace_info;
  logic        ts_valid;
  logic [63:0] ts_value;
  logic        err_pulse;

  dfd_dst_vlt_decoder #(
    .DEBUG_SIGNAL_WIDTH(64),
    .BE_WIDTH(8),
    .SRC_ID_WIDTH(4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_xor_en     (cfg_xor_en),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_byte        (in_byte),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_source_id  (out_source_id),
    .out_packet_lost(out_packet_lost),
    .out_trace_info (out_trace_info),
    .ts_valid       (ts_valid),
    .ts_value       (ts_value),
    .err_pulse      (err_pulse)
  );

  always #5 clk = ~clk;

  typedef enum int {K_NONE, K_DATA, K_TS, K_ERR} kind_e;
  typedef struct {
    logic [79:0] bytes;
    int          len;
    logic        xor_en;
    kind_e       kind;
    logic [63:0] data;
    logic [3:0]  src;
    logic        lost;
    logic [1:0]  tinfo;
    logic [63:0] ts;
  } vec_t;

  localparam int NV = 13;
  vec_t vt[NV];

  int nvec = 0;
  int nfail = 0;

  int          n_out = 0, n_ts = 0, n_err = 0;
  logic [63:0] mon_data, mon_ts;
  logic [3:0]  mon_src;
  logic        mon_lost;
  logic [1:0]  mon_tinfo;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      n_out++;
      mon_data  = out_data;
      mon_src   = out_source_id;
      mon_lost  = out_packet_lost;
      mon_tinfo = out_trace_info;
    end
    if (ts_valid) begin
      n_ts++;
      mon_ts = ts_value;
    end
    if (err_pulse) n_err++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      nvec++;
      nfail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_out, b_ts, b_err;

    //            bytes (first byte leftmost)      len xor kind    data                   src   lost  ti     ts
    vt[0]  = '{80'h01FF1122334455667788, 10, 1'b1, K_DATA, 64'h8877665544332211, 4'h0, 1'b0, 2'b01, 64'h0};
    vt[1]  = '{80'h81,                    1, 1'b1, K_NONE, 64'h0,                4'h0, 1'b0, 2'b00, 64'h0};
    vt[2]  = '{80'h0002F0,                3, 1'b1, K_DATA, 64'h887766554433D211, 4'h0, 1'b0, 2'b00, 64'h0};
    vt[3]  = '{80'h81,                    1, 1'b1, K_NONE, 64'h0,                4'h0, 1'b0, 2'b00, 64'h0};
    vt[4]  = '{80'h2081AABB,              4, 1'b0, K_DATA, 64'hBB000000000000AA, 4'h4, 1'b0, 2'b00, 64'h0};
    vt[5]  = '{80'h8210EFCDAB8967452301, 10, 1'b1, K_TS,   64'h0,                4'h0, 1'b0, 2'b00, 64'h0123456789ABCDEF};
    vt[6]  = '{80'h000100,                3, 1'b1, K_DATA, 64'hBB000000000000AA, 4'h0, 1'b0, 2'b00, 64'h0};
    vt[7]  = '{80'h0000,                  2, 1'b1, K_ERR,  64'h0,                4'h0, 1'b0, 2'b00, 64'h0};
    vt[8]  = '{80'h8250,                  2, 1'b1, K_ERR,  64'h0,                4'h0, 1'b0, 2'b00, 64'h0};
    vt[9]  = '{80'h80,                    1, 1'b1, K_ERR,  64'h0,                4'h0, 1'b0, 2'b00, 64'h0};
    vt[10] = '{80'h83,                    1, 1'b1, K_NONE, 64'h0,                4'h0, 1'b0, 2'b00, 64'h0};
    vt[11] = '{80'h0C030102,              4, 1'b1, K_DATA, 64'hBB000000000002AB, 4'h1, 1'b1, 2'b00, 64'h0};
    vt[12] = '{80'h7E805A,                3, 1'b1, K_DATA, 64'h5A00000000000000, 4'hF, 1'b1, 2'b10, 64'h0};

    reset_n    = 1'b0;
    cfg_xor_en = 1'b0;
    in_valid   = 1'b0;
    in_byte    = 8'h00;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_ts_valid", 64'(ts_valid), 64'd0);
    check("rst_ts_value", ts_value, 64'd0);
    check("rst_err", 64'(err_pulse), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      cfg_xor_en = vt[i].xor_en;
      b_out = n_out;
      b_ts  = n_ts;
      b_err = n_err;
      for (int k = 0; k < vt[i].len; k++) send_byte(vt[i].bytes[8*(vt[i].len-1-k) +: 8]);
      repeat (4) @(negedge clk);
      case (vt[i].kind)
        K_DATA: begin
          check($sformatf("v%0d_out_cnt", i), 64'(n_out - b_out), 64'd1);
          check($sformatf("v%0d_data", i), mon_data, vt[i].data);
          check($sformatf("v%0d_src", i), 64'(mon_src), 64'(vt[i].src));
          check($sformatf("v%0d_lost", i), 64'(mon_lost), 64'(vt[i].lost));
          check($sformatf("v%0d_tinfo", i), 64'(mon_tinfo), 64'(vt[i].tinfo));
          check($sformatf("v%0d_err_cnt", i), 64'(n_err - b_err), 64'd0);
        end
        K_TS: begin
          check($sformatf("v%0d_ts_cnt", i), 64'(n_ts - b_ts), 64'd1);
          check($sformatf("v%0d_ts_value", i), mon_ts, vt[i].ts);
          check($sformatf("v%0d_out_cnt", i), 64'(n_out - b_out), 64'd0);
        end
        K_ERR: begin
          check($sformatf("v%0d_err_cnt", i), 64'(n_err - b_err), 64'd1);
          check($sformatf("v%0d_out_cnt", i), 64'(n_out - b_out), 64'd0);
        end
        default: begin
          check($sformatf("v%0d_quiet", i),
                64'((n_out - b_out) + (n_ts - b_ts) + (n_err - b_err)), 64'd0);
        end
      endcase
    end

    // Stalled result: outputs held and input blocked until out_ready returns.
    cfg_xor_en = 1'b1;
    out_ready  = 1'b0;
    b_out = n_out;
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h77);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_out_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d_out_data", c), out_data, 64'h77);
      check($sformatf("bp%0d_tinfo", c), 64'(out_trace_info), 64'd1);
      check($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'd0);
    end
    check("bp_no_accept", 64'(n_out - b_out), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("bp_accept_cnt", 64'(n_out - b_out), 64'd1);
    check("bp_accept_data", mon_data, 64'h77);
    check("bp_out_valid_drop", 64'(out_valid), 64'd0);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);

    // Reset in the middle of a payload drops the partial packet and clears the reference.
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", out_data, 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    b_out = n_out;
    cfg_xor_en = 1'b1;
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h5C);
    repeat (4) @(negedge clk);
    check("post_rst_cnt", 64'(n_out - b_out), 64'd1);
    check("post_rst_data", mon_data, 64'h5C);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
